// File: rtl/pulp_cluster_package.sv
// Cluster-wide constants shared by the cluster peripherals.
// Holds the SoC event drop-counter width and saturation value.
package pulp_cluster_package;

    localparam int unsigned SOC_EVT_DROP_CNT_W = 16;
    localparam logic [SOC_EVT_DROP_CNT_W-1:0] SOC_EVT_DROP_CNT_SAT = 16'hFFFF;

    function automatic logic [SOC_EVT_DROP_CNT_W-1:0] soc_evt_drop_cnt_inc(
        input logic [SOC_EVT_DROP_CNT_W-1:0] cnt
    );
        return (cnt == SOC_EVT_DROP_CNT_SAT) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/cluster_soc_evt_fifo_mem.sv
// Register-file storage for the SoC event FIFO: one write port, one
// asynchronous read at the read pointer. Contents are not reset.
module cluster_soc_evt_fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/cluster_soc_evt_buffer.sv
// SoC event FIFO between the SoC event input and the cluster peripherals'
// soc_periph_evt_* port. Define CLUSTER_SOC_EVT_DROP_CNT_EN to build the drop counter.
module cluster_soc_evt_buffer
    import pulp_cluster_package::*;
#(
    parameter int unsigned EVNT_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          evt_valid_i,
    input  logic [EVNT_WIDTH-1:0]         evt_data_i,
    output logic                          evt_valid_o,
    output logic [EVNT_WIDTH-1:0]         evt_data_o,
    input  logic                          evt_ready_i,
    output logic [$clog2(DEPTH):0]        level_o,
    output logic                          overflow_o,
    input  logic                          clr_overflow_i,
    output logic [SOC_EVT_DROP_CNT_W-1:0] drop_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]           wr_ptr_q;
    logic [AW:0]           rd_ptr_q;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  overflow_q;
    logic [EVNT_WIDTH-1:0] head_data;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign pop   = !empty && evt_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push  = evt_valid_i && (!full || pop);
    assign drop  = evt_valid_i && full && !pop;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    cluster_soc_evt_fifo_mem #(
        .WIDTH (EVNT_WIDTH),
        .DEPTH (DEPTH)
    ) i_fifo_mem (
        .clk   (clk_i),
        .we    (push && rst_ni),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (evt_data_i),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (head_data)
    );

    // Storage is never reset, so the head is masked to zero while empty.
    assign evt_valid_o = !empty;
    assign evt_data_o  = empty ? '0 : head_data;
    assign level_o     = wr_ptr_q - rd_ptr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (clr_overflow_i) begin
            overflow_q <= 1'b0;
        end
    end

    assign overflow_o = overflow_q;

`ifdef CLUSTER_SOC_EVT_DROP_CNT_EN
    logic [SOC_EVT_DROP_CNT_W-1:0] drop_cnt_q;

    // A drop wins over a coincident clear and restarts the count at one.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
        end else if (drop) begin
            drop_cnt_q <= clr_overflow_i ? SOC_EVT_DROP_CNT_W'(1) : soc_evt_drop_cnt_inc(drop_cnt_q);
        end else if (clr_overflow_i) begin
            drop_cnt_q <= '0;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cluster_soc_evt_buffer.sv
// Self-checking bench for cluster_soc_evt_buffer: queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_cluster_soc_evt_buffer;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 8;

`ifdef CLUSTER_SOC_EVT_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         evt_valid = 1'b0;
    logic [W-1:0] evt_data = '0;
    logic         evt_ready = 1'b0;
    logic         clr = 1'b0;
    logic         valid_out;
    logic [W-1:0] data_out;
    logic [3:0]   level;
    logic         overflow;
    logic [15:0]  drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] mq[$];
    bit           m_ovf = 1'b0;
    int           m_cnt = 0;
    bit           chk_en = 1'b0;

    always #5 clk = ~clk;

    cluster_soc_evt_buffer #(.EVNT_WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .evt_valid_i    (evt_valid),
        .evt_data_i     (evt_data),
        .evt_valid_o    (valid_out),
        .evt_data_o     (data_out),
        .evt_ready_i    (evt_ready),
        .level_o        (level),
        .overflow_o     (overflow),
        .clr_overflow_i (clr),
        .drop_cnt_o     (drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: event queue updated from the inputs seen at each rising edge.
    initial forever begin
        bit pop_m, full_m, drop_m;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_cnt  = 0;
            chk_en = 1'b1;
        end else begin
            pop_m  = (mq.size() > 0) && evt_ready;
            full_m = (mq.size() == DEPTH);
            drop_m = evt_valid && full_m && !pop_m;
            if (pop_m) void'(mq.pop_front());
            if (evt_valid && !drop_m) mq.push_back(evt_data);
            if (drop_m) begin
                m_ovf = 1'b1;
                m_cnt = clr ? 1 : ((m_cnt == 65535) ? m_cnt : m_cnt + 1);
            end else if (clr) begin
                m_ovf = 1'b0;
                m_cnt = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("model_level", 32'(level), 32'(mq.size()));
            chk("model_valid", 32'(valid_out), 32'(mq.size() > 0));
            chk("model_data", 32'(data_out), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
            chk("model_overflow", 32'(overflow), 32'(m_ovf));
            chk("model_drop_cnt", 32'(drop_cnt), CNT_EN ? 32'(m_cnt) : 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input bit r, input bit c);
        evt_valid = v;
        evt_data  = d;
        evt_ready = r;
        clr       = c;
    endtask

    task automatic fill(input logic [W-1:0] base);
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, base + W'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        int rdy_bias;
        drive(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_level", 32'(level), 0);
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);

        // Single push latency.
        drive(1'b1, 8'h2A, 1'b1, 1'b0);
        tick();
        chk("lat_valid", 32'(valid_out), 1);
        chk("lat_data", 32'(data_out), 32'h2A);
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        chk("lat_valid_after", 32'(valid_out), 0);
        chk("lat_level_after", 32'(level), 0);

        // Ordering under backpressure.
        fill(8'h01);
        chk("bp_level", 32'(level), 8);
        chk("bp_valid", 32'(valid_out), 1);
        chk("bp_data", 32'(data_out), 32'h01);
        tick();
        chk("bp_hold_data", 32'(data_out), 32'h01);

        // Overflow: three drops, then clear.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'hE0 + W'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_drop_cnt", 32'(drop_cnt), CNT_EN ? 32'd3 : 32'd0);
        chk("ovf_level", 32'(level), 8);
        chk("ovf_head", 32'(data_out), 32'h01);
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("clr_flag", 32'(overflow), 0);
        chk("clr_drop_cnt", 32'(drop_cnt), 0);

        // Push and pop together while full.
        drive(1'b1, 8'hAA, 1'b1, 1'b0);
        tick();
        chk("fpp_level", 32'(level), 8);
        chk("fpp_overflow", 32'(overflow), 0);
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk("fpp_order", 32'(data_out), (k < 7) ? 32'(k + 2) : 32'hAA);
            tick();
        end
        chk("fpp_empty", 32'(valid_out), 0);

        // Clear coinciding with a drop.
        fill(8'h40);
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        tick();
        tick();
        chk("col_pre_cnt", 32'(drop_cnt), CNT_EN ? 32'd2 : 32'd0);
        drive(1'b1, 8'h78, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("col_flag", 32'(overflow), 1);
        chk("col_drop_cnt", 32'(drop_cnt), CNT_EN ? 32'd1 : 32'd0);

        // Mid-stream reset with a push presented.
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'h90 + W'(i), 1'b0, 1'b0);
            tick();
        end
        chk("mrst_pre_level", 32'(level), 5);
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("mrst_level", 32'(level), 0);
        chk("mrst_valid", 32'(valid_out), 0);
        chk("mrst_overflow", 32'(overflow), 0);

        // Randomized traffic with phases of varying consumer readiness.
        rdy_bias = 3;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) rdy_bias = int'($urandom_range(0, 3));
            drive($urandom_range(0, 9) < 6, W'($urandom),
                  int'($urandom_range(0, 3)) <= rdy_bias, $urandom_range(0, 19) == 0);
            rst_n = !($urandom_range(0, 599) == 0);
            tick();
        end
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) tick();
        chk("drain_level", 32'(level), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cluster_soc_evt_buffer.md
CLUSTER_SOC_EVT_BUFFER -- requirements
Module: cluster_soc_evt_buffer

Interface
REQ-001 SHALL have parameter EVNT_WIDTH, default 8, the SoC event ID width.
REQ-002 SHALL have parameter DEPTH, default 8, the number of FIFO entries; it SHALL be a power of two and at least 2.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port evt_valid_i, input, 1 bit: a SoC event pulse; the source has no backpressure.
REQ-006 SHALL have port evt_data_i, input, EVNT_WIDTH bits: the event ID, qualified by evt_valid_i.
REQ-007 SHALL have port evt_valid_o, input-side partner output, 1 bit: the head entry is valid; it feeds the event unit soc_periph_evt_valid_i.
REQ-008 SHALL have port evt_data_o, output, EVNT_WIDTH bits: the head entry ID; it feeds soc_periph_evt_data_i.
REQ-009 SHALL have port evt_ready_i, input, 1 bit: consumer ready, driven from soc_periph_evt_ready_o.
REQ-010 SHALL have port level_o, output, $clog2(DEPTH)+1 bits: the current occupancy.
REQ-011 SHALL have port overflow_o, output, 1 bit: a sticky flag indicating an event was dropped.
REQ-012 SHALL have port clr_overflow_i, input, 1 bit: a one-cycle pulse that clears overflow_o and drop_cnt_o.
REQ-013 SHALL have port drop_cnt_o, output, 16 bits: the saturating count of dropped events (see REQ-025).

Function
REQ-014 SHALL implement a DEPTH-entry circular FIFO using read and write pointers of width $clog2(DEPTH)+1, with the MSB used as the wrap bit.
REQ-015 SHALL treat the FIFO as empty when the pointers are equal, and as full when the index bits are equal and the wrap bits differ.
REQ-016 SHALL complete a push when evt_valid_i=1 and (not full, or pop in the same cycle); the entry is written at the write pointer, which then increments and wraps.
REQ-017 SHALL complete a pop when evt_valid_o=1 and evt_ready_i=1; the read pointer increments and wraps.
REQ-018 SHALL drive evt_valid_o as "not empty" and evt_data_o as the entry at the read pointer, both directly from registers (registered output, no combinational path from inputs).
REQ-019 SHALL have a latency of exactly 1 cycle from a push into an empty FIFO to evt_valid_o=1.
REQ-020 SHALL hold evt_valid_o and evt_data_o stable while evt_valid_o=1 and evt_ready_i=0.
REQ-021 SHALL, on a simultaneous push and pop when full, accept both; level stays DEPTH and there is no drop.
REQ-022 SHALL, on a simultaneous push and pop when empty, take no pass-through; the push is stored and the pop is not possible, since evt_valid_o=0.
REQ-023 SHALL keep level_o equal to the write pointer minus the read pointer, modulo 2·DEPTH, in the range 0..DEPTH.
REQ-024 SHALL, on a push while full with no pop, drop the event, leave the FIFO contents unchanged, and set overflow_o=1 on the next cycle.
REQ-025 SHALL, on each drop, increment drop_cnt_o, saturating at 16'hFFFF.
REQ-026 SHALL, on clr_overflow_i=1, clear overflow_o to 0 and drop_cnt_o to 0 on the next cycle.
REQ-027 SHALL, when clr_overflow_i and a drop coincide, give the drop priority: overflow_o=1 and drop_cnt_o=1.
REQ-028 SHALL leave FIFO traffic unaffected by clr_overflow_i.

Reset
REQ-029 SHALL, when rst_ni=0 at a clock edge, set both pointers to 0, evt_valid_o=0, level_o=0, overflow_o=0 and drop_cnt_o=0.
REQ-030 SHALL leave evt_data_o undefined-content storage but drive it to 0 while empty after reset.
REQ-031 SHALL, on reset asserted mid-operation, discard all queued events and ignore pushes presented during reset.
REQ-032 SHALL implement no asynchronous reset path.

Configuration
REQ-033 SHALL, when macro CLUSTER_SOC_EVT_DROP_CNT_EN is defined, implement the 16-bit saturating drop counter as in REQ-025 to REQ-027.
REQ-034 SHALL, when CLUSTER_SOC_EVT_DROP_CNT_EN is undefined, tie drop_cnt_o to 0 and synthesize no counter flops, while overflow_o behaviour is unchanged.

Structure
REQ-035 SHALL place the drop-counter width constant (16) and its saturation value in pulp_cluster_package, alongside the existing peripheral constants.
REQ-036 SHALL have no mandatory sub-module; an optional sub-module cluster_soc_evt_fifo_mem (register-file storage with write port and read-at-pointer) SHALL be instantiated once if used.
REQ-037 SHALL be instantiated between the SoC event input and the cluster peripherals soc_periph_evt_* port.

Verification
REQ-038 SHALL verify push latency: one push of ID 8'h2A into an empty FIFO with ready=1 -> evt_valid_o=1 and data=8'h2A on the next cycle only, then level returns to 0.
REQ-039 SHALL verify order and backpressure: with ready=0, push 8'h01..8'h08 -> level_o=8, valid held, data=8'h01; with ready=1 afterwards -> 8'h01..8'h08 popped in order over 8 cycles.
REQ-040 SHALL verify overflow: with the FIFO full and ready=0, push 3 more events -> overflow_o=1, drop_cnt_o=3, contents unchanged; a clr pulse -> 0 and 0.
REQ-041 SHALL verify full push+pop: with the FIFO full, push 8'hAA while ready=1 -> no drop, level stays 8, and 8'hAA emerges last.
REQ-042 SHALL verify clr/drop collision: clr_overflow_i coincides with a drop -> overflow_o=1, drop_cnt_o=1.
REQ-043 SHALL verify mid-stream reset: with level=5, pulse rst_ni=0 for 1 cycle with evt_valid_i=1 -> level_o=0, evt_valid_o=0 and overflow_o=0 on the following cycle.
